fp_round_normalizer: RTL and testbench

- Consumes the sign and 12-bit magnitude from the two's-complement-to-sign-magnitude stage.
- Produces the 8-bit floating-point word: 1 sign bit, 3-bit exponent E, 4-bit significand F; value = F × 2^E.
- Multi-cycle: a start/done handshake, a serial left-shift leading-one search, then a rounding step with saturation.
- Sits between the sign-magnitude converter and the FP output/display register.

---
 rtl/fp_round_normalizer_if.sv | 42 ++++
 rtl/fp_round_normalizer.sv | 182 ++++++++++++++++++
 tb/tb_fp_round_normalizer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_round_normalizer_if.sv
// -----------------------------------------------------------------------------
// fp_round_normalizer_if
//
// Purpose: bundles the request/result signals of fp_round_normalizer so the
// block and its producer/consumer share one connection object.
//
// Signals:
//   start  - request pulse, honoured only while the normalizer is idle
//   s_in   - sign from the sign-magnitude stage
//   sm_in  - 12-bit magnitude from the sign-magnitude stage
//   busy   - normalizer is working on a request (any state but idle)
//   done   - one-cycle pulse, result valid from this cycle on
//   s_out  - result sign
//   e_out  - result exponent (3 bits)
//   f_out  - result significand (4 bits); value = f_out * 2^e_out
//
// Modports:
//   master - the requester: drives start/s_in/sm_in, observes the result
//   slave  - the normalizer itself
// -----------------------------------------------------------------------------
interface fp_round_normalizer_if #(
  parameter int MAG_W = 12
);
  logic             start;
  logic             s_in;
  logic [MAG_W-1:0] sm_in;
  logic             busy;
  logic             done;
  logic             s_out;
  logic [2:0]       e_out;
  logic [3:0]       f_out;

  modport master (
    output start, s_in, sm_in,
    input  busy, done, s_out, e_out, f_out
  );

  modport slave (
    input  start, s_in, sm_in,
    output busy, done, s_out, e_out, f_out
  );
endinterface

// File: rtl/fp_round_normalizer.sv
// -----------------------------------------------------------------------------
// fp_round_normalizer
//
// Purpose: converts a sign + 12-bit magnitude into an 8-bit floating-point
// word {sign, E[2:0], F[3:0]} with value F * 2^E. The leading one is found by
// a serial left-shift search (at most 7 steps), then the result is rounded
// (or truncated) and saturated to E = 7, F = 15 when it does not fit.
//
// Ports:
//   clk  - system clock, all state changes on its rising edge
//   rst  - asynchronous active-high reset
//   bus  - fp_round_normalizer_if.slave (start, s_in, sm_in, busy, done,
//          s_out, e_out, f_out)
//
// Configuration macro:
//   FP_ROUND_EN - defined: round-half-up on the bit below F, with overflow
//                 renormalisation and saturation.
//                 undefined: plain truncation; only sm_in = 0x800 saturates.
//   Latency is identical in both builds.
//
// Timing: with n shift steps the done pulse appears n+3 edges after the edge
// that samples start; the saturated 0x800 request takes 2 edges.
// -----------------------------------------------------------------------------
module fp_round_normalizer #(
  parameter int MAG_W   = 12,
  parameter int EXP_MAX = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_round_normalizer_if.slave  bus
);

  // Working register holds the lower 11 magnitude bits; bit 11 only ever
  // appears for the -2048 code, which takes the saturation path instead.
  localparam int         W_W    = MAG_W - 1;
  localparam logic [2:0] EC_MAX = 3'(EXP_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W_W-1:0] w_q,     w_d;
  logic [2:0]     ec_q,    ec_d;
  logic           sat_q,   sat_d;
  logic           sign_q,  sign_d;
  logic           busy_q,  busy_d;
  logic           done_q,  done_d;
  logic           s_out_q, s_out_d;
  logic [2:0]     e_out_q, e_out_d;
  logic [3:0]     f_out_q, f_out_d;

  // Rounding datapath, evaluated from the working register in ROUND.
  logic [4:0] f_sum;
  logic [3:0] ec_inc;
  logic [3:0] f_rnd;
  logic [2:0] e_rnd;

  // Round (or truncate) the top four working bits and apply saturation.
  always_comb begin
`ifdef FP_ROUND_EN
    f_sum = {1'b0, w_q[10:7]} + {4'b0000, w_q[6]};
`else
    f_sum = {1'b0, w_q[10:7]};
`endif
    // A carry out of F means 1111 + 1 = 10000: renormalise to 1000 and
    // bump the exponent. Computed 4 bits wide so an exponent of 8 is visible.
    if (f_sum[4]) begin
      f_rnd  = 4'd8;
      ec_inc = {1'b0, ec_q} + 4'd1;
    end else begin
      f_rnd  = f_sum[3:0];
      ec_inc = {1'b0, ec_q};
    end
    if (sat_q || ec_inc[3]) begin
      e_rnd = 3'd7;
      f_rnd = 4'd15;
    end else begin
      e_rnd = ec_inc[2:0];
    end
  end

  // Next-state and next-output logic for the IDLE/SHIFT/ROUND/DONE sequence.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    ec_d    = ec_q;
    sat_d   = sat_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_out_d = s_out_q;
    e_out_d = e_out_q;
    f_out_d = f_out_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sign_d = bus.s_in;
          w_d    = bus.sm_in[W_W-1:0];
          ec_d   = EC_MAX;
          busy_d = 1'b1;
          // Bit 11 set can only be -2048: no shift search, straight to
          // saturation.
          if (bus.sm_in[MAG_W-1]) begin
            sat_d   = 1'b1;
            state_d = ST_ROUND;
          end else begin
            sat_d   = 1'b0;
            state_d = ST_SHIFT;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        // Stop once the leading one sits in bit 10, or after 7 shifts; in the
        // latter case E = 0 and F holds sm_in[3:0] exactly.
        if (w_q[10] || (ec_q == 3'd0)) begin
          state_d = ST_ROUND;
        end else begin
          w_d  = {w_q[W_W-2:0], 1'b0};
          ec_d = ec_q - 3'd1;
        end
      end
      ST_ROUND: begin
        s_out_d = sign_q;
        e_out_d = e_rnd;
        f_out_d = f_rnd;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // start is ignored here; the requester must re-assert it in IDLE.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sat_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        sat_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any request without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      ec_q    <= 3'd0;
      sat_q   <= 1'b0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_out_q <= 1'b0;
      e_out_q <= 3'd0;
      f_out_q <= 4'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      ec_q    <= ec_d;
      sat_q   <= sat_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_out_q <= s_out_d;
      e_out_q <= e_out_d;
      f_out_q <= f_out_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s_out = s_out_q;
  assign bus.e_out = e_out_q;
  assign bus.f_out = f_out_q;

endmodule

// File: tb/tb_fp_round_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fp_round_normalizer
//
// Directed-vector bench for fp_round_normalizer. Each test task issues
// requests, measures the done latency in clock edges, counts done pulses over
// a fixed window and compares the result word against hand-computed values.
// Expectations that depend on FP_ROUND_EN follow the same macro.
// -----------------------------------------------------------------------------
module tb_fp_round_normalizer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  fp_round_normalizer_if bus ();

  fp_round_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and watch 24 edges. lat is the edge index (edge 1
  // samples start) of the first done, -1 if none. When mid_edge > 0, start is
  // raised again so that it is sampled on edge mid_edge+1.
  task automatic do_req(input logic s, input logic [11:0] mag, input int mid_edge,
                        output int lat, output int dcnt,
                        output logic busy1, output logic busy_after);
    int edge_n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.s_in  = s;
    bus.sm_in = mag;
    @(negedge clk);
    bus.start  = 1'b0;
    edge_n     = 1;
    lat        = -1;
    dcnt       = 0;
    busy1      = bus.busy;
    busy_after = 1'b1;
    while (edge_n <= 24) begin
      if (bus.done === 1'b1) begin
        dcnt++;
        if (lat < 0) lat = edge_n;
      end
      if ((lat >= 0) && (edge_n == lat + 1)) busy_after = bus.busy;
      bus.start = (edge_n == mid_edge);
      @(negedge clk);
      edge_n++;
    end
    bus.start = 1'b0;
  endtask

  // Run one request and compare latency, handshake and result inline.
  task automatic test_one(input string name, input logic s, input logic [11:0] mag,
                          input int mid_edge, input int exp_lat,
                          input logic exp_s, input logic [2:0] exp_e,
                          input logic [3:0] exp_f);
    int   lat, dcnt;
    logic b1, ba;
    do_req(s, mag, mid_edge, lat, dcnt, b1, ba);
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (dcnt !== 1) begin
      tests_failed++;
      $display("FAIL %s done_count: got %0d, expected 1", name, dcnt);
    end
    tests_run++;
    if (b1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy_after_start: got %b, expected 1", name, b1);
    end
    tests_run++;
    if (ba !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy_after_done: got %b, expected 0", name, ba);
    end
    tests_run++;
    if ({bus.s_out, bus.e_out, bus.f_out} !== {exp_s, exp_e, exp_f}) begin
      tests_failed++;
      $display("FAIL %s result: got s=%b e=%0d f=%0d, expected s=%b e=%0d f=%0d",
               name, bus.s_out, bus.e_out, bus.f_out, exp_s, exp_e, exp_f);
    end
  endtask

  // Reset state: every output 0 while reset is held.
  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.s_in  = 1'b0;
    bus.sm_in = 12'h000;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.s_out, bus.e_out, bus.f_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b done=%b s=%b e=%0d f=%0d, expected all 0",
               bus.busy, bus.done, bus.s_out, bus.e_out, bus.f_out);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_busy: got %b, expected 0", bus.busy);
    end
  endtask

  // 422 -> two shifts, E=5 F=13; a start in the DONE cycle must be ignored.
  task automatic test_basic();
    test_one("basic_1a6", 1'b0, 12'h1A6, 5, 5, 1'b0, 3'd5, 4'd13);
  endtask

  // Rounding overflow and saturation behaviour at the top of the range.
  task automatic test_round();
`ifdef FP_ROUND_EN
    test_one("round_3e0", 1'b0, 12'h3E0, 0, 4, 1'b0, 3'd7, 4'd8);
`else
    test_one("round_3e0", 1'b0, 12'h3E0, 0, 4, 1'b0, 3'd6, 4'd15);
`endif
    test_one("round_7f0", 1'b0, 12'h7F0, 0, 3, 1'b0, 3'd7, 4'd15);
  endtask

  // -2048 takes the short saturation path.
  task automatic test_sat();
    test_one("sat_800", 1'b1, 12'h800, 0, 2, 1'b1, 3'd7, 4'd15);
  endtask

  // Small values: full 7-step search, exact E=0 encoding, start while busy.
  task automatic test_small();
    test_one("small_005", 1'b0, 12'h005, 3, 10, 1'b0, 3'd0, 4'd5);
    test_one("zero_000", 1'b1, 12'h000, 0, 10, 1'b1, 3'd0, 4'd0);
  endtask

  // Two requests issued back to back with different signs.
  task automatic test_back_to_back();
    test_one("b2b_a", 1'b1, 12'h1A6, 0, 5, 1'b1, 3'd5, 4'd13);
    test_one("b2b_b", 1'b0, 12'h005, 0, 10, 1'b0, 3'd0, 4'd5);
  endtask

  // Reset two cycles into SHIFT: outputs clear at once, no done, then recover.
  task automatic test_reset_abort();
    int dcnt;
    test_one("pre_abort_7f0", 1'b1, 12'h7F0, 0, 3, 1'b1, 3'd7, 4'd15);
    @(negedge clk);
    bus.start = 1'b1;
    bus.s_in  = 1'b1;
    bus.sm_in = 12'h005;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.s_out, bus.e_out, bus.f_out} !== 10'b0) begin
      tests_failed++;
      $display("FAIL abort_async_clear: got busy=%b done=%b s=%b e=%0d f=%0d, expected all 0",
               bus.busy, bus.done, bus.s_out, bus.e_out, bus.f_out);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    tests_run++;
    if (dcnt !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", dcnt);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: got busy=%b, expected 0", bus.busy);
    end
    test_one("post_abort_1a6", 1'b0, 12'h1A6, 0, 5, 1'b0, 3'd5, 4'd13);
  endtask

  // Test sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_small();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
